// File: rtl/data_mem_pkg.sv
// Shared types and constants for the load/store data memory.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package data_mem_pkg;

  // Bytes per array word; also the number of byte lanes.
  localparam int WORD_BYTES = 4;

  // Access size, using the RISC-V funct3 encoding of loads and stores.
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  // Request/response sequencing; a single request is in flight at a time.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store mask/data placement, alignment checks, load extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [2:0]            st_size,
  input  logic [1:0]            st_lane,
  input  logic [31:0]           st_wdata,
  input  logic [2:0]            ld_size,
  input  logic [1:0]            ld_lane,
  input  logic [31:0]           ld_word,
  output logic [WORD_BYTES-1:0] st_be,
  output logic [31:0]           st_wdata_sh,
  output logic                  misalign,
  output logic                  size_bad,
  output logic [31:0]           ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: lane mask, replicated data and alignment/size legality.
  // Data is replicated across lanes so the mask alone picks the target bytes.
  always_comb begin
    st_be       = '0;
    st_wdata_sh = '0;
    misalign    = 1'b0;
    size_bad    = 1'b0;
    case (st_size)
      MEM_B, MEM_BU: begin
        st_be       = 4'b0001 << st_lane;
        st_wdata_sh = {4{st_wdata[7:0]}};
      end
      MEM_H, MEM_HU: begin
        st_be       = st_lane[1] ? 4'b1100 : 4'b0011;
        st_wdata_sh = {2{st_wdata[15:0]}};
        misalign    = st_lane[0];
      end
      MEM_W: begin
        st_be       = 4'b1111;
        st_wdata_sh = st_wdata;
        misalign    = (st_lane != 2'b00);
      end
      default: size_bad = 1'b1;
    endcase
  end

  // Load side: pick the addressed lane(s) and sign- or zero-extend.
  always_comb begin
    ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
    ld_half = ld_word[{ld_lane[1], 4'b0000} +: 16];
    ld_data = '0;
    case (ld_size)
      MEM_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_BU:  ld_data = {24'h0, ld_byte};
      MEM_H:   ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_HU:  ld_data = {16'h0, ld_half};
      MEM_W:   ld_data = ld_word;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_ls.sv
// Word-organised data memory with RISC-V byte/half/word loads and stores and error reporting.
// Latency: rsp_valid rises LATENCY cycles after the accepting edge (LATENCY legal range 1..4).
// Backpressure: one request outstanding; req_ready low until the response is taken via rsp_ready.
module data_memory_ls
  import data_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH);
  // WAIT lasts LATENCY-1 cycles; the counter's final value is LATENCY-2.
  localparam logic [1:0] CNT_LAST = 2'((LATENCY > 1) ? (LATENCY - 2) : 0);

  mem_state_e state, state_nxt;
  logic [1:0] cnt;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_pipe [LATENCY];

  logic                  req_fire;
  logic [IDX_W-1:0]      idx;
  logic                  oor;
  logic                  req_err;
  logic [WORD_BYTES-1:0] st_be;
  logic [31:0]           st_wdata_sh;
  logic                  misalign;
  logic                  size_bad;
  logic [31:0]           ld_data;

  logic       cap_we;
  logic       cap_err;
  logic [2:0] cap_size;
  logic [1:0] cap_lane;

  assign req_fire = req_valid && req_ready;
  assign idx      = req_addr[IDX_W+1:2];
  assign oor      = (req_addr[ADDR_W-1:2] >= DEPTH_LIM);
  assign req_err  = oor || misalign || size_bad;

  // Store steering comes from the live request; load extension uses the captured one.
  mem_lane_align u_align (
    .st_size     (req_size),
    .st_lane     (req_addr[1:0]),
    .st_wdata    (req_wdata),
    .ld_size     (cap_size),
    .ld_lane     (cap_lane),
    .ld_word     (rd_pipe[LATENCY-1]),
    .st_be       (st_be),
    .st_wdata_sh (st_wdata_sh),
    .misalign    (misalign),
    .size_bad    (size_bad),
    .ld_data     (ld_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and request-side ready.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY > 1) state_nxt = WAIT;
          else             state_nxt = RESP;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter: runs only while in WAIT, restarts from zero each request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (state == WAIT) cnt <= cnt + 2'd1;
    else                    cnt <= '0;
  end

  // Capture request attributes needed to shape the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we   <= 1'b0;
      cap_err  <= 1'b0;
      cap_size <= '0;
      cap_lane <= '0;
    end else if (req_fire) begin
      cap_we   <= req_we;
      cap_err  <= req_err;
      cap_size <= req_size;
      cap_lane <= req_addr[1:0];
    end
  end

  // Array write at the accept edge; errored stores leave the array untouched.
  always_ff @(posedge clk) begin
    if (req_fire && req_we && !req_err) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (st_be[b]) mem[idx][8*b +: 8] <= st_wdata_sh[8*b +: 8];
      end
    end
  end

  // Read pipeline: word fetched at the accept edge, then LATENCY-1 delay stages.
  // Stage 0 holds between requests, so later stages settle on the same word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      if (req_fire) rd_pipe[0] <= oor ? 32'h0 : mem[idx];
      for (int i = 1; i < LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // Response register: loaded on the first RESP cycle, held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == RESP && !rsp_valid) begin
      rsp_valid <= 1'b1;
      rsp_err   <= cap_err;
      rsp_rdata <= (cap_err || cap_we) ? 32'h0 : ld_data;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule
